rf_read_port: RTL and testbench
===============================

# rf_read_port

Read-side controller for the register file's bitcell array. Accepts a two-address read request over a valid/ready handshake, drives one-hot read enables onto the shared tristate bitlines for exactly one cycle, and captures both bitline values. It applies R0-is-zero and same-cycle write forwarding, then presents the result on a valid/ready response channel. It sits between decode and the bitcell array and is the only driver of the array's read enables.

## Interface
- NREG, 16: number of registers (one-hot enable width); address width is log2(NREG).
- WIDTH, 16: register/bitline width.

- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  read request present.
- req_ready  out  1  request accepted when req_valid & req_ready at a rising edge.
- req_addr1  in  log2(NREG)  port-1 register address.
- req_addr2  in  log2(NREG)  port-2 register address.
- wr_en  in  1  register-file write this cycle (same signal fed to the bitcells' WriteEnable decode).
- wr_addr  in  log2(NREG)  write address.
- wr_data  in  WIDTH  write data.
- rd_en1  out  NREG  one-hot read enables for bitline 1 (all-zero = bitline released).
- rd_en2  out  NREG  one-hot read enables for bitline 2.
- bitline1  in  WIDTH  bitline 1 value from the array.
- bitline2  in  WIDTH  bitline 2 value from the array.
- rsp_valid  out  1  response data valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data1  out  WIDTH  read data, port 1.
- rsp_data2  out  WIDTH  read data, port 2.

## Operation
- States: IDLE, DRIVE, HOLD. All state, address latches and outputs are registered.
- IDLE: req_ready=1, rd_en*=0, rsp_valid=0. On accept, latch both addresses and go to DRIVE.
- DRIVE (exactly one cycle):
  - rd_en1 = one-hot(addr1), rd_en2 = one-hot(addr2). Both may select the same register.
  - Address 0 drives no enable on that port (all-zero), and its captured data is 0.
  - At the end of the cycle, capture per port: 0 if addr==0; else wr_data if wr_en & wr_addr==addr (write forwarding, because the cell updates only at that edge); else the bitline value.
  - Go to HOLD.
- HOLD: rsp_valid=1, rsp_data* stable, rd_en*=0.
  - If rsp_ready and req_valid: accept the new request and go to DRIVE.
  - If rsp_ready and no request: go to IDLE.
  - Otherwise stay in HOLD.
- Held data is a snapshot. Writes during HOLD do not alter rsp_data*.
- req_ready = (state==IDLE) | (state==HOLD & rsp_ready). It is combinational from state and rsp_ready, with no combinational path from req_valid.
- At most one bit of each rd_en vector is ever high. Both vectors are all-zero outside DRIVE.

## Timing
- Reset (async, immediate): state=IDLE, rd_en1=rd_en2=0, rsp_valid=0, rsp_data1=rsp_data2=0, address latches=0. req_ready is 1 after reset deassertion.
- Request accepted at edge T: DRIVE during cycle T..T+1. Bitlines are sampled at edge T+1, and rsp_valid=1 from T+1.
- Latency: 2 edges from accept to rsp_valid.
- Peak throughput: one request per 2 cycles, via back-to-back HOLD→DRIVE.
- Reset asserted during DRIVE: enables drop asynchronously in the same cycle and no response is produced.
- Reset asserted during HOLD: the response is discarded and rsp_valid falls immediately.
- rsp_valid never deasserts without rsp_ready, except on reset.
- A write at edge T+1 to an address being read produces the new data (write-before-read). A write at edge T or earlier is visible through the bitline.

## Test plan
- Reset/idle: assert rst mid-DRIVE -> rd_en1=rd_en2=0 and rsp_valid=0 in the same cycle. After release, req_ready=1 and rsp_data*=0.
- Basic read: preload R3=0x1234 and R7=0xBEEF, request (3,7) -> in DRIVE, rd_en1=16'h0008 and rd_en2=16'h0080. Two edges after accept, rsp_data1=0x1234 and rsp_data2=0xBEEF.
- R0 and aliasing: request (0,5) with R5=0x00AA and bitline1 forced to 0xFFFF -> rd_en1=0 and rsp_data1=0x0000, rsp_data2=0x00AA. Request (5,5) -> both ports return 0x00AA, each vector one-hot.
- Forwarding: during DRIVE for (9,2), wr_en=1, wr_addr=9, wr_data=0x5A5A while R9 still reads 0x1111 on the bitline -> rsp_data1=0x5A5A.
- Backpressure and snapshot: hold rsp_ready=0 for 5 cycles while writing R3=0x9999 -> rsp_valid stays 1, data stays 0x1234, req_ready=0. Then rsp_ready=1 with req_valid=1 -> new request accepted that edge, and next cycle is DRIVE.
- Back-to-back stream: 8 requests with rsp_ready tied 1 -> one response every 2 cycles in order, with no rd_en bit high outside DRIVE.

Source files
------------

// File: rtl/rf_read_port.sv
// rf_read_port: read-side controller for the register file bitcell array.
// Takes a two-address request and pulses one-hot read enables for one cycle.
// It captures both bitlines, applying R0-is-zero and same-edge write forwarding.
// The captured pair is held on a valid/ready response channel until consumed.
module rf_read_port #(
    parameter int NREG  = 16,
    parameter int WIDTH = 16,
    localparam int AW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AW-1:0]    req_addr1,
    input  logic [AW-1:0]    req_addr2,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [NREG-1:0]  rd_en1,
    output logic [NREG-1:0]  rd_en2,
    input  logic [WIDTH-1:0] bitline1,
    input  logic [WIDTH-1:0] bitline2,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data1,
    output logic [WIDTH-1:0] rsp_data2
);

    typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    addr1_q, addr1_d;
    logic [AW-1:0]    addr2_q, addr2_d;
    logic [NREG-1:0]  rd_en1_q, rd_en1_d;
    logic [NREG-1:0]  rd_en2_q, rd_en2_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data1_q, rsp_data1_d;
    logic [WIDTH-1:0] rsp_data2_q, rsp_data2_d;
    logic             accept;

    // R0 is hardwired to zero, so it never gets an enable on the bitline.
    function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] a);
        logic [NREG-1:0] v;
        v = '0;
        if (a != '0) begin
            v[a] = 1'b1;
        end
        return v;
    endfunction

    // A write landing on the sampling edge has not reached the cell yet, so forward it.
    function automatic logic [WIDTH-1:0] capture(
        input logic [AW-1:0]    a,
        input logic [WIDTH-1:0] bl,
        input logic             we,
        input logic [AW-1:0]    wa,
        input logic [WIDTH-1:0] wd
    );
        if (a == '0) begin
            return '0;
        end else if (we && (wa == a)) begin
            return wd;
        end
        return bl;
    endfunction

    assign req_ready = (state_q == IDLE) || ((state_q == HOLD) && rsp_ready);
    assign accept    = req_valid && req_ready;

    // Next-state and registered-output computation for IDLE/DRIVE/HOLD.
    always_comb begin
        state_d     = state_q;
        addr1_d     = addr1_q;
        addr2_d     = addr2_q;
        rd_en1_d    = '0;
        rd_en2_d    = '0;
        rsp_valid_d = rsp_valid_q;
        rsp_data1_d = rsp_data1_q;
        rsp_data2_d = rsp_data2_q;
        unique case (state_q)
            IDLE, HOLD: begin
                if (accept) begin
                    state_d     = DRIVE;
                    addr1_d     = req_addr1;
                    addr2_d     = req_addr2;
                    rd_en1_d    = onehot(req_addr1);
                    rd_en2_d    = onehot(req_addr2);
                    rsp_valid_d = 1'b0;
                end else if ((state_q == HOLD) && rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            DRIVE: begin
                rsp_data1_d = capture(addr1_q, bitline1, wr_en, wr_addr, wr_data);
                rsp_data2_d = capture(addr2_q, bitline2, wr_en, wr_addr, wr_data);
                rsp_valid_d = 1'b1;
                state_d     = HOLD;
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State, address latches and outputs; reset clears enables and response at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr1_q     <= '0;
            addr2_q     <= '0;
            rd_en1_q    <= '0;
            rd_en2_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data1_q <= '0;
            rsp_data2_q <= '0;
        end else begin
            state_q     <= state_d;
            addr1_q     <= addr1_d;
            addr2_q     <= addr2_d;
            rd_en1_q    <= rd_en1_d;
            rd_en2_q    <= rd_en2_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data1_q <= rsp_data1_d;
            rsp_data2_q <= rsp_data2_d;
        end
    end

    assign rd_en1    = rd_en1_q;
    assign rd_en2    = rd_en2_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data1 = rsp_data1_q;
    assign rsp_data2 = rsp_data2_q;

endmodule

// File: tb/tb_rf_read_port.sv
// tb_rf_read_port: bench for rf_read_port with a behavioural bitcell array and
// a queue of expected response pairs.
module tb_rf_read_port;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_addr1;
    logic [3:0]  req_addr2;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [15:0] rd_en1;
    logic [15:0] rd_en2;
    logic [15:0] bitline1;
    logic [15:0] bitline2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data1;
    logic [15:0] rsp_data2;

    logic [15:0] mem [16];
    logic [15:0] shadow [16];
    logic        force1;
    logic [31:0] exp_q [$];
    int          checks = 0;
    int          passes = 0;

    rf_read_port #(.NREG(16), .WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr1(req_addr1), .req_addr2(req_addr2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en1(rd_en1), .rd_en2(rd_en2),
        .bitline1(bitline1), .bitline2(bitline2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data1(rsp_data1), .rsp_data2(rsp_data2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bitcell array: cells update on the write edge.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Bitlines: wired-OR of the enabled cells, optionally forced high.
    always_comb begin
        bitline1 = '0;
        bitline2 = '0;
        for (int i = 0; i < 16; i++) begin
            if (rd_en1[i]) bitline1 = bitline1 | mem[i];
            if (rd_en2[i]) bitline2 = bitline2 | mem[i];
        end
        if (force1) bitline1 = 16'hFFFF;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
        shadow[a] = d;
    endtask

    function automatic logic [15:0] exp_val(input logic [3:0] a);
        return (a == 4'd0) ? 16'h0000 : shadow[a];
    endfunction

    // Presents a request and returns #1 after the edge that accepted it.
    task automatic do_req(input logic [3:0] a1, input logic [3:0] a2);
        bit ok = 0;
        req_valid = 1'b1; req_addr1 = a1; req_addr2 = a2;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (req_ready) ok = 1;
            tick();
        end
        req_valid = 1'b0;
        checks++;
        if (!ok) $display("FAIL req_accept_timeout got ready=0 exp ready=1");
        else passes++;
    endtask

    task automatic wait_rsp;
        bit seen = 0;
        logic [31:0] e;
        rsp_ready = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (rsp_valid) begin
                seen = 1;
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rsp_unexpected got %h_%h exp none", rsp_data1, rsp_data2);
                end else begin
                    e = exp_q.pop_front();
                    if ({rsp_data1, rsp_data2} !== e)
                        $display("FAIL rsp_data got %h_%h exp %h_%h", rsp_data1, rsp_data2, e[31:16], e[15:0]);
                    else passes++;
                end
            end
            tick();
        end
        if (!seen) begin
            checks++;
            $display("FAIL rsp_timeout got valid=0 exp valid=1");
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b exp 1", req_ready); else passes++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); else passes++;
        checks++; if ({rsp_data1, rsp_data2} !== 32'h0) $display("FAIL reset_rsp_data got %h_%h exp 0_0", rsp_data1, rsp_data2); else passes++;
        // Reset in the middle of DRIVE.
        do_req(4'd3, 4'd7);
        checks++; if (rd_en1 !== 16'h0008) $display("FAIL drive_pre_reset_en1 got %h exp 0008", rd_en1); else passes++;
        #2 rst = 1'b1;
        #1;
        checks++; if ({rd_en1, rd_en2} !== 32'h0) $display("FAIL reset_drive_en got %h_%h exp 0_0", rd_en1, rd_en2); else passes++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_drive_valid got %b exp 0", rsp_valid); else passes++;
        tick();
        rst = 1'b0;
        tick();
        checks++; if (req_ready !== 1'b1) $display("FAIL post_reset_ready got %b exp 1", req_ready); else passes++;
        checks++; if ({rsp_data1, rsp_data2} !== 32'h0) $display("FAIL post_reset_data got %h_%h exp 0_0", rsp_data1, rsp_data2); else passes++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL post_reset_valid got %b exp 0", rsp_valid); else passes++;
        // Reset during HOLD discards the response.
        rsp_ready = 1'b0;
        write_reg(4'd4, 16'h4444);
        do_req(4'd4, 4'd4);
        tick();
        checks++; if (rsp_valid !== 1'b1) $display("FAIL hold_pre_reset_valid got %b exp 1", rsp_valid); else passes++;
        #2 rst = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_hold_valid got %b exp 0", rsp_valid); else passes++;
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        write_reg(4'd3, 16'h1234);
        write_reg(4'd7, 16'hBEEF);
        do_req(4'd3, 4'd7);
        checks++; if (rd_en1 !== 16'h0008) $display("FAIL basic_rd_en1 got %h exp 0008", rd_en1); else passes++;
        checks++; if (rd_en2 !== 16'h0080) $display("FAIL basic_rd_en2 got %h exp 0080", rd_en2); else passes++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL basic_early_valid got %b exp 0", rsp_valid); else passes++;
        exp_q.push_back({16'h1234, 16'hBEEF});
        tick();
        checks++; if (rsp_valid !== 1'b1) $display("FAIL basic_latency got %b exp 1", rsp_valid); else passes++;
        checks++; if ({rd_en1, rd_en2} !== 32'h0) $display("FAIL basic_hold_en got %h_%h exp 0_0", rd_en1, rd_en2); else passes++;
        wait_rsp();
    endtask

    task automatic test_r0_alias;
        write_reg(4'd5, 16'h00AA);
        force1 = 1'b1;
        do_req(4'd0, 4'd5);
        checks++; if (rd_en1 !== 16'h0000) $display("FAIL r0_rd_en1 got %h exp 0000", rd_en1); else passes++;
        checks++; if (rd_en2 !== 16'h0020) $display("FAIL r0_rd_en2 got %h exp 0020", rd_en2); else passes++;
        exp_q.push_back({16'h0000, 16'h00AA});
        wait_rsp();
        force1 = 1'b0;
        do_req(4'd5, 4'd5);
        checks++; if (rd_en1 !== 16'h0020) $display("FAIL alias_rd_en1 got %h exp 0020", rd_en1); else passes++;
        checks++; if (rd_en2 !== 16'h0020) $display("FAIL alias_rd_en2 got %h exp 0020", rd_en2); else passes++;
        exp_q.push_back({16'h00AA, 16'h00AA});
        wait_rsp();
    endtask

    task automatic test_forwarding;
        write_reg(4'd9, 16'h1111);
        write_reg(4'd2, 16'h2222);
        do_req(4'd9, 4'd2);
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h5A5A;
        shadow[9] = 16'h5A5A;
        exp_q.push_back({16'h5A5A, 16'h2222});
        #1;
        checks++; if (bitline1 !== 16'h1111) $display("FAIL fwd_bitline got %h exp 1111", bitline1); else passes++;
        tick();
        wr_en = 1'b0;
        wait_rsp();
    endtask

    task automatic test_backpressure;
        logic [31:0] e;
        rsp_ready = 1'b0;
        do_req(4'd3, 4'd7);
        exp_q.push_back({16'h1234, 16'hBEEF});
        tick();
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h9999;
        shadow[3] = 16'h9999;
        for (int i = 0; i < 5; i++) begin
            checks++; if (rsp_valid !== 1'b1) $display("FAIL bp_valid cyc%0d got %b exp 1", i, rsp_valid); else passes++;
            checks++; if (rsp_data1 !== 16'h1234) $display("FAIL bp_snapshot cyc%0d got %h exp 1234", i, rsp_data1); else passes++;
            checks++; if (req_ready !== 1'b0) $display("FAIL bp_req_ready cyc%0d got %b exp 0", i, req_ready); else passes++;
            tick();
        end
        wr_en = 1'b0;
        rsp_ready = 1'b1; req_valid = 1'b1; req_addr1 = 4'd3; req_addr2 = 4'd3;
        #1;
        checks++; if (req_ready !== 1'b1) $display("FAIL bp_release_ready got %b exp 1", req_ready); else passes++;
        e = exp_q.pop_front();
        checks++; if ({rsp_data1, rsp_data2} !== e) $display("FAIL bp_rsp got %h_%h exp %h_%h", rsp_data1, rsp_data2, e[31:16], e[15:0]); else passes++;
        tick();
        req_valid = 1'b0;
        checks++; if (rd_en1 !== 16'h0008) $display("FAIL bp_next_drive got %h exp 0008", rd_en1); else passes++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL bp_valid_drop got %b exp 0", rsp_valid); else passes++;
        exp_q.push_back({16'h9999, 16'h9999});
        wait_rsp();
    endtask

    task automatic test_back_to_back;
        logic [3:0]  a1s [8];
        logic [3:0]  a2s [8];
        logic [31:0] e;
        int k = 0, nrsp = 0, last = 0;
        bit in_drive = 0, acc;
        for (int unsigned i = 1; i < 16; i++) write_reg(4'(i), 16'(i * 16'h0101) ^ 16'hA000);
        for (int i = 0; i < 8; i++) begin
            a1s[i] = 4'($urandom_range(0, 15));
            a2s[i] = 4'($urandom_range(0, 15));
        end
        a1s[0] = 4'd0;
        a2s[3] = a1s[3];
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr1 = a1s[0]; req_addr2 = a2s[0];
        #1;
        for (int cyc = 0; cyc < 40 && nrsp < 8; cyc++) begin
            checks++; if (!$onehot0(rd_en1) || !$onehot0(rd_en2)) $display("FAIL b2b_onehot got %h_%h exp onehot0", rd_en1, rd_en2); else passes++;
            if (!in_drive) begin
                checks++; if ({rd_en1, rd_en2} !== 32'h0) $display("FAIL b2b_en_outside_drive got %h_%h exp 0_0", rd_en1, rd_en2); else passes++;
            end
            if (rsp_valid) begin
                checks++;
                if (exp_q.size() == 0) $display("FAIL b2b_unexpected got %h_%h exp none", rsp_data1, rsp_data2);
                else begin
                    e = exp_q.pop_front();
                    if ({rsp_data1, rsp_data2} !== e) $display("FAIL b2b_rsp%0d got %h_%h exp %h_%h", nrsp, rsp_data1, rsp_data2, e[31:16], e[15:0]);
                    else passes++;
                end
                if (nrsp > 0) begin
                    checks++; if (cyc - last != 2) $display("FAIL b2b_spacing got %0d exp 2", cyc - last); else passes++;
                end
                last = cyc;
                nrsp++;
            end
            acc = req_valid && req_ready;
            if (acc) exp_q.push_back({exp_val(a1s[k]), exp_val(a2s[k])});
            tick();
            in_drive = acc;
            if (acc) begin
                k++;
                if (k < 8) begin
                    req_addr1 = a1s[k]; req_addr2 = a2s[k];
                end else req_valid = 1'b0;
                #1;
            end
        end
        req_valid = 1'b0;
        checks++; if (nrsp != 8) $display("FAIL b2b_count got %0d exp 8", nrsp); else passes++;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr1 = '0; req_addr2 = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; rsp_ready = 1'b1; force1 = 1'b0;
        for (int i = 0; i < 16; i++) shadow[i] = '0;
        test_reset();
        test_basic();
        test_r0_alias();
        test_forwarding();
        test_backpressure();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
